uart_sipo_rx: RTL and testbench

Serial-in/parallel-out UART receiver. It is the receive-side counterpart of the 11-bit transmit frame: start bit 0, 8 data bits LSB first, parity bit, stop bit 1. It runs on the oversampling baud clock from the BaudGen unit and recovers bytes from the serial line. Results are presented on a held parallel output with a valid/ack handshake, plus per-frame parity, framing and overrun status.

---
 rtl/uart_sipo_rx_if.sv | 28 ++
 rtl/uart_sipo_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_sipo_rx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sipo_rx_if.sv
// uart_sipo_rx_if: parallel-side bundle of the UART receiver.
//   data_out      - last committed byte
//   data_valid    - high from frame commit until rd_ack
//   parity_error  - parity status of the last committed frame
//   framing_error - stop bit sampled low in the last committed frame
//   overrun_error - sticky, a frame committed while data_valid was still high
//   rd_ack        - consumer acknowledge, clears data_valid
// Modports: master = receiver side, slave = consumer side.
interface uart_sipo_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_error;
    logic              framing_error;
    logic              overrun_error;
    logic              rd_ack;

    modport master (
        output data_out, data_valid, parity_error, framing_error, overrun_error,
        input  rd_ack
    );

    modport slave (
        input  data_out, data_valid, parity_error, framing_error, overrun_error,
        output rd_ack
    );
endinterface

// File: rtl/uart_sipo_rx.sv
// uart_sipo_rx: oversampling UART receiver (start, DATA_W bits LSB first, parity, stop).
// Ports:
//   i_baud_clk    - oversampling clock, all logic on posedge
//   i_reset       - synchronous active-high reset
//   i_data_rx     - asynchronous serial line, idle high
//   i_parity_type - 0 even, 1 odd; captured at the parity-bit sample point
//   o_active_flag - high while a frame is being received
//   o_done_flag   - inverse of o_active_flag
//   rx_if         - parallel result and valid/ack handshake (master modport)
// Optional build macro RX_MAJORITY_VOTE_EN: every bit is decided by a 2-of-3 vote around
// its sample point (needs OVERSAMPLE >= 8); decisions land one cycle later.
module uart_sipo_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_W     = 8
) (
    input  logic           i_baud_clk,
    input  logic           i_reset,
    input  logic           i_data_rx,
    input  logic           i_parity_type,
    output logic           o_active_flag,
    output logic           o_done_flag,
    uart_sipo_rx_if.master rx_if
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(DATA_W - 1);
`ifdef RX_MAJORITY_VOTE_EN
    // Start is voted one tick late; DATA starts at tick 1 so later sample points keep
    // their nominal position while each decision trails it by one cycle.
    localparam logic [TW-1:0] TickStart = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TickFirst = TW'(1);
`else
    localparam logic [TW-1:0] TickStart = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TickFirst = '0;
`endif

    logic              r_sync1, r_sync2;
    logic [2:0]        r_state;
    logic [TW-1:0]     r_tick;
    logic [IW-1:0]     r_bit_idx;
    logic              r_armed;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_s, r_par_type;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid, r_perr, r_ferr, r_ovr;

    logic [2:0]        w_state_nxt;
    logic [TW-1:0]     w_tick_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic              w_armed_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_par_s_nxt, w_par_type_nxt;
    logic [DATA_W-1:0] w_data_out_nxt;
    logic              w_valid_nxt, w_perr_nxt, w_ferr_nxt, w_ovr_nxt;

    logic              w_rx_s, w_samp_pt, w_in_bit;
    logic              w_start_bit, w_dec_vld, w_dec_bit, w_commit, w_stop_bad;
    logic [2:0]        w_dec_st;
    logic [IW-1:0]     w_dec_idx;

    assign w_rx_s    = r_sync2;
    assign w_samp_pt = (r_tick == TickLast);
    assign w_in_bit  = (r_state == StData) || (r_state == StParity) || (r_state == StStop);

`ifdef RX_MAJORITY_VOTE_EN
    // r_hist[0] is rx_s one cycle ago, r_hist[1] two cycles ago.
    logic [1:0]    r_hist;
    logic          r_pend;
    logic [2:0]    r_pend_st;
    logic [IW-1:0] r_pend_idx;
    logic          w_maj;

    assign w_maj = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
    assign w_start_bit = w_maj;
    assign w_dec_vld   = r_pend;
    assign w_dec_st    = r_pend_st;
    assign w_dec_idx   = r_pend_idx;
    assign w_dec_bit   = w_maj;

    always_ff @(posedge i_baud_clk) begin
        if (i_reset) begin
            r_hist     <= 2'b11;
            r_pend     <= 1'b0;
            r_pend_st  <= StIdle;
            r_pend_idx <= '0;
        end else begin
            r_hist     <= {r_hist[0], w_rx_s};
            r_pend     <= w_samp_pt && w_in_bit;
            r_pend_st  <= r_state;
            r_pend_idx <= r_bit_idx;
        end
    end
`else
    assign w_start_bit = w_rx_s;
    assign w_dec_vld   = w_samp_pt && w_in_bit;
    assign w_dec_st    = r_state;
    assign w_dec_idx   = r_bit_idx;
    assign w_dec_bit   = w_rx_s;
`endif

    assign w_commit   = w_dec_vld && (w_dec_st == StStop);
    // A low stop bit must disarm start detection even if IDLE is already watching the line.
    assign w_stop_bad = w_commit && !w_dec_bit;

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = (r_state == StIdle) ? '0 : r_tick + TW'(1);
        w_idx_nxt      = r_bit_idx;
        w_armed_nxt    = r_armed;
        w_shift_nxt    = r_shift;
        w_par_s_nxt    = r_par_s;
        w_par_type_nxt = r_par_type;

        case (r_state)
            StIdle: begin
                if (w_rx_s) w_armed_nxt = 1'b1;
                if (r_armed && !w_rx_s && !w_stop_bad) begin
                    w_state_nxt = StStart;
                    w_tick_nxt  = '0;
                end
            end
            StStart: begin
                if (r_tick == TickStart) begin
                    if (!w_start_bit) begin
                        w_state_nxt = StData;
                        w_tick_nxt  = TickFirst;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = StIdle;
                        w_tick_nxt  = '0;
                    end
                end
            end
            StData: begin
                if (w_samp_pt) begin
                    w_tick_nxt = '0;
                    if (r_bit_idx == IdxLast) w_state_nxt = StParity;
                    else                      w_idx_nxt   = r_bit_idx + IW'(1);
                end
            end
            StParity: begin
                if (w_samp_pt) begin
                    w_state_nxt    = StStop;
                    w_tick_nxt     = '0;
                    w_par_type_nxt = i_parity_type;
                end
            end
            StStop: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (w_samp_pt) begin
                    w_state_nxt = StIdle;
                    w_tick_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_tick_nxt  = '0;
            end
        endcase

        if (w_dec_vld) begin
            case (w_dec_st)
                StData:   w_shift_nxt[w_dec_idx] = w_dec_bit;
                StParity: w_par_s_nxt = w_dec_bit;
                StStop:   if (!w_dec_bit) w_armed_nxt = 1'b0;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = r_valid;
        w_perr_nxt     = r_perr;
        w_ferr_nxt     = r_ferr;
        w_ovr_nxt      = r_ovr;
        if (w_commit) begin
            w_data_out_nxt = r_shift;
            w_perr_nxt     = (^r_shift) ^ r_par_s ^ r_par_type;
            w_ferr_nxt     = ~w_dec_bit;
            w_valid_nxt    = 1'b1;
            // Commit beats a same-cycle ack: the new byte stays valid, no overrun.
            if (r_valid && !rx_if.rd_ack) w_ovr_nxt = 1'b1;
            else if (rx_if.rd_ack)        w_ovr_nxt = 1'b0;
        end else if (rx_if.rd_ack) begin
            w_valid_nxt = 1'b0;
            w_ovr_nxt   = 1'b0;
        end
    end

    always_ff @(posedge i_baud_clk) begin
        if (i_reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= StIdle;
            r_tick     <= '0;
            r_bit_idx  <= '0;
            r_armed    <= 1'b1;
            r_shift    <= '0;
            r_par_s    <= 1'b0;
            r_par_type <= 1'b0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync1    <= i_data_rx;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_armed    <= w_armed_nxt;
            r_shift    <= w_shift_nxt;
            r_par_s    <= w_par_s_nxt;
            r_par_type <= w_par_type_nxt;
            r_data_out <= w_data_out_nxt;
            r_valid    <= w_valid_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
            r_ovr      <= w_ovr_nxt;
        end
    end

    assign o_active_flag       = (r_state != StIdle);
    assign o_done_flag         = ~o_active_flag;
    assign rx_if.data_out      = r_data_out;
    assign rx_if.data_valid    = r_valid;
    assign rx_if.parity_error  = r_perr;
    assign rx_if.framing_error = r_ferr;
    assign rx_if.overrun_error = r_ovr;
endmodule

// File: tb/tb_uart_sipo_rx.sv
// tb_uart_sipo_rx: self-checking bench for uart_sipo_rx (directed table, random frames
// against a frame-level reference model, and multi-cycle corner sequences).
`timescale 1ns/1ps
module tb_uart_sipo_rx;
    localparam int OS = 16;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int ExpLat      = 169;
    localparam int GlitchIdleN = 11;
`else
    localparam int ExpLat      = 168;
    localparam int GlitchIdleN = 10;
`endif

    logic clk = 1'b0;
    logic rst, rx, ptype, act, done;

    uart_sipo_rx_if #(.DATA_W(8)) rx_if ();

    uart_sipo_rx #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
        .i_baud_clk   (clk),
        .i_reset      (rst),
        .i_data_rx    (rx),
        .i_parity_type(ptype),
        .o_active_flag(act),
        .o_done_flag  (done),
        .rx_if        (rx_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       pt;
        logic       stop;
        int         low_after;
        logic [7:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   line_q[$];
    int   act_n, val_n, act_after_val;
    bit   act_tr[0:1023];

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic push_level(input bit v, input int n);
        repeat (n) line_q.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit pbit, input bit stop);
        push_level(1'b0, OS);
        for (int k = 0; k < 8; k++) push_level(d[k], OS);
        push_level(pbit, OS);
        push_level(stop, OS);
    endtask

    // Plays the queued line levels one per cycle; records when active first rises,
    // when data_valid first rises, and whether a new frame starts after that commit.
    task automatic run_line(input int max_n, input int ack_n);
        act_n = -1;
        val_n = -1;
        act_after_val = 0;
        for (int n = 0; n < max_n && line_q.size() > 0; n++) begin
            rx = line_q.pop_front();
            rx_if.rd_ack = (n == ack_n);
            @(posedge clk);
            #1;
            if (n < 1024) act_tr[n] = act;
            if (act && act_n < 0) act_n = n;
            if (rx_if.data_valid && val_n < 0) val_n = n;
            else if (val_n >= 0 && act) act_after_val = 1;
        end
        rx_if.rd_ack = 1'b0;
        rx = 1'b1;
        line_q.delete();
    endtask

    task automatic do_ack();
        rx_if.rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_if.rd_ack = 1'b0;
    endtask

    // Reference: decode the 11-bit frame by its definition.
    task automatic model(input logic [7:0] d, input bit pbit, input bit pt, input bit stop,
                         output logic [7:0] ed, output logic eperr, output logic eferr);
        bit frame [11];
        int ones;
        frame[0] = 1'b0;
        for (int k = 0; k < 8; k++) frame[1+k] = d[k];
        frame[9]  = pbit;
        frame[10] = stop;
        ed = 8'h00;
        for (int k = 0; k < 8; k++) if (frame[1+k]) ed = ed | 8'(1 << k);
        ones = pt ? 1 : 0;
        for (int j = 1; j <= 9; j++) ones += frame[j] ? 1 : 0;
        eperr = (ones % 2) == 1;
        eferr = (frame[10] == 1'b0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] ed, input logic eperr,
                               input logic eferr);
        chk({tag, "_data"}, int'(rx_if.data_out), int'(ed));
        chk({tag, "_perr"}, int'(rx_if.parity_error), int'(eperr));
        chk({tag, "_ferr"}, int'(rx_if.framing_error), int'(eferr));
        chk({tag, "_ovr"}, int'(rx_if.overrun_error), 0);
        chk({tag, "_start_edge"}, act_n, 2);
        chk({tag, "_latency"}, val_n - act_n, ExpLat);
        chk({tag, "_no_restart"}, act_after_val, 0);
        do_ack();
        chk({tag, "_ack_clears"}, int'(rx_if.data_valid), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [5];
        logic [7:0] ed;
        logic       eperr, eferr;
        int         vcount;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 0,  8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 0,  8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 50, 8'h55, 1'b0, 1'b1};
        vecs[4] = '{8'h0F, 1'b0, 1'b0, 1'b1, 0,  8'h0F, 1'b0, 1'b0};

        rst = 1'b1;
        rx = 1'b1;
        ptype = 1'b0;
        rx_if.rd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(rx_if.data_valid), 0);
        chk("rst_data", int'(rx_if.data_out), 0);
        chk("rst_active", int'(act), 0);
        chk("rst_done", int'(done), 1);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            ptype = vecs[i].pt;
            push_frame(vecs[i].d, vecs[i].pbit, vecs[i].stop);
            push_level(1'b0, vecs[i].low_after);
            push_level(1'b1, 24);
            run_line(1000, -1);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_perr,
                        vecs[i].exp_ferr);
        end

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            bit         pb, pt, sb;
            d  = 8'($urandom_range(255, 0));
            pb = 1'($urandom_range(1, 0));
            pt = 1'($urandom_range(1, 0));
            sb = ($urandom_range(3, 0) != 0);
            model(d, pb, pt, sb, ed, eperr, eferr);
            ptype = pt;
            push_frame(d, pb, sb);
            push_level(1'b1, 24);
            run_line(1000, -1);
            check_frame($sformatf("rnd%0d", i), ed, eperr, eferr);
        end

        // Short low glitch: START entered, then abandoned at the start-bit sample.
        push_level(1'b0, 4);
        push_level(1'b1, 40);
        run_line(1000, -1);
        chk("glitch_start_edge", act_n, 2);
        chk("glitch_still_start", int'(act_tr[GlitchIdleN-1]), 1);
        chk("glitch_back_idle", int'(act_tr[GlitchIdleN]), 0);
        chk("glitch_no_valid", val_n, -1);

        // Back-to-back frames without ack: overrun, newest byte kept.
        ptype = 1'b0;
        push_frame(8'h11, 1'b0, 1'b1);
        push_frame(8'h22, 1'b0, 1'b1);
        push_level(1'b1, 24);
        run_line(1000, -1);
        chk("b2b_data", int'(rx_if.data_out), 8'h22);
        chk("b2b_valid", int'(rx_if.data_valid), 1);
        chk("b2b_ovr", int'(rx_if.overrun_error), 1);
        chk("b2b_perr", int'(rx_if.parity_error), 0);
        do_ack();
        chk("b2b_ack_valid", int'(rx_if.data_valid), 0);
        chk("b2b_ack_ovr", int'(rx_if.overrun_error), 0);

        // Ack landing on the second commit cycle: commit wins, no overrun.
        push_frame(8'h33, 1'b0, 1'b1);
        push_frame(8'h44, 1'b0, 1'b1);
        push_level(1'b1, 24);
        run_line(1000, 16 * 11 + 2 + ExpLat);
        chk("ackcommit_first", val_n, 2 + ExpLat);
        chk("ackcommit_data", int'(rx_if.data_out), 8'h44);
        chk("ackcommit_valid", int'(rx_if.data_valid), 1);
        chk("ackcommit_ovr", int'(rx_if.overrun_error), 0);
        do_ack();

        // Reset in the middle of a frame: aborted, outputs back to reset values.
        push_frame(8'h99, 1'b1, 1'b1);
        run_line(60, -1);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_data", int'(rx_if.data_out), 0);
        chk("midrst_valid", int'(rx_if.data_valid), 0);
        chk("midrst_errs", int'({rx_if.parity_error, rx_if.framing_error,
                                 rx_if.overrun_error}), 0);
        chk("midrst_active", int'(act), 0);
        chk("midrst_done", int'(done), 1);
        vcount = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (rx_if.data_valid || act) vcount++;
        end
        chk("midrst_quiet", vcount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
